gate_sweep_ctrl: RTL and testbench
==================================

GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2: cycles each input vector is held before z is sampled; legal range 1..15.
REQ-002 The block SHALL have parameter EXPECT, 4 bits, default 4'b1110: expected z per vector, indexed by {x,y}; the default is the 2-input OR truth table.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to begin a sweep.
REQ-006 The block SHALL have port x, output, 1 bit: first operand driven to the gate under test.
REQ-007 The block SHALL have port y, output, 1 bit: second operand driven to the gate under test.
REQ-008 The block SHALL have port z, input, 1 bit: result returned from the gate under test.
REQ-009 The block SHALL have port busy, output, 1 bit: high while the sweep is in the APPLY or CHECK state.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a sweep.
REQ-011 The block SHALL have port pass, output, 1 bit: high when the last sweep had zero mismatches.
REQ-012 The block SHALL have port fail_count, output, 3 bits: number of mismatching vectors, 0..4.
REQ-013 The block SHALL have port fail_map, output, 4 bits: bit i set when vector i mismatched.
REQ-014 The block SHALL have port vec_idx, output, 2 bits: current or last vector index; x = vec_idx[1], y = vec_idx[0].

Function
REQ-015 The block SHALL implement FSM states IDLE, APPLY, CHECK and DONE; all outputs SHALL be registered.
REQ-016 In IDLE, start=1 SHALL, on the next cycle, enter APPLY with vec_idx=0 and settle counter=SETTLE_CYCLES-1, and SHALL clear fail_map, fail_count and pass.
REQ-017 APPLY SHALL hold x/y from vec_idx, decrement the settle counter each cycle, and enter CHECK on the cycle after the counter reads 0; APPLY therefore lasts exactly SETTLE_CYCLES cycles.
REQ-018 CHECK SHALL last one cycle and compare z with EXPECT[vec_idx]; on mismatch it SHALL set fail_map[vec_idx] and increment fail_count.
REQ-019 From CHECK, the FSM SHALL enter DONE if vec_idx==3, else increment vec_idx and re-enter APPLY with the counter reloaded.
REQ-020 DONE SHALL last one cycle with done=1 and pass=(final fail_count==0), then return to IDLE.
REQ-021 A full sweep SHALL take 4*(SETTLE_CYCLES+1) busy cycles, with done asserted on the following cycle.
REQ-022 The FSM SHALL ignore start in APPLY, CHECK and DONE; there SHALL be no queuing.
REQ-023 pass, fail_count, fail_map and vec_idx SHALL hold their values in IDLE until the next accepted start.
REQ-024 x and y SHALL equal vec_idx bits in every state, so they hold the last vector in IDLE.

Reset
REQ-025 While rst=1, the FSM SHALL go to IDLE and x, y, busy, done, pass, fail_count, fail_map, vec_idx and the settle counter SHALL all be 0 on the next edge.
REQ-026 rst SHALL take priority over start, including when rst is asserted mid-sweep; the partial sweep SHALL be discarded and no done pulse issued.

Configuration
REQ-027 With macro GATE_SWEEP_FAIL_STOP_EN defined, a mismatch in CHECK SHALL go directly to DONE, with vec_idx holding the failing index and only that bit set in fail_map.
REQ-028 With GATE_SWEEP_FAIL_STOP_EN undefined, all four vectors SHALL always be applied regardless of mismatches.

Verification
REQ-029 Setup: SETTLE_CYCLES=2, OR model on z, start pulsed at cycle 0 -> busy cycles 1-12, done=1 at cycle 13, pass=1, fail_count=0, fail_map=0000.
REQ-030 Setup: z stuck at 0, macro undefined -> done at cycle 13, fail_map=1110, fail_count=3, pass=0.
REQ-031 Setup: z driven by an AND model, EXPECT default -> fail_map=0110, fail_count=2, pass=0.
REQ-032 Setup: GATE_SWEEP_FAIL_STOP_EN defined, z stuck at 0 -> mismatch at CHECK in cycle 6, done at cycle 7, vec_idx=1, fail_map=0010, fail_count=1.
REQ-033 Setup: start pulsed again at cycle 4 -> no effect, done still at cycle 13; rst=1 at cycle 5 -> all outputs 0 at cycle 6, no done pulse.
REQ-034 Setup: SETTLE_CYCLES=1 with OR model -> done at cycle 9, pass=1; x/y sequence 00,01,10,11 with each vector held 2 cycles.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// Applies all four {x,y} vectors to a 2-input gate, samples z after a settle window, and
// accumulates a mismatch map/count; GATE_SWEEP_FAIL_STOP_EN ends the sweep at the first mismatch.
module gate_sweep_ctrl #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECT        = 4'b1110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       x,
  output logic       y,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] fail_count,
  output logic [3:0] fail_map,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] map_q, map_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       pass_q, pass_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       mism;
  logic       last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    map_d   = map_q;
    fcnt_d  = fcnt_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    mism    = 1'b0;
    last    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_APPLY;
          vec_d   = 2'd0;
          cnt_d   = RELOAD;
          map_d   = 4'd0;
          fcnt_d  = 3'd0;
          pass_d  = 1'b0;
        end
      end
      S_APPLY: begin
        if (cnt_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CHECK: begin
        mism = (z != EXPECT[vec_q]);
        if (mism) begin
          map_d[vec_q] = 1'b1;
          fcnt_d       = fcnt_q + 3'd1;
        end
`ifdef GATE_SWEEP_FAIL_STOP_EN
        last = mism || (vec_q == 2'd3);
`else
        last = (vec_q == 2'd3);
`endif
        if (last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (fcnt_d == 3'd0);
        end else begin
          state_d = S_APPLY;
          vec_d   = vec_q + 2'd1;
          cnt_d   = RELOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // busy/done are registered alongside the state so they line up with it exactly
    busy_d = (state_d == S_APPLY) || (state_d == S_CHECK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      vec_q   <= 2'd0;
      map_q   <= 4'd0;
      fcnt_q  <= 3'd0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      map_q   <= map_d;
      fcnt_q  <= fcnt_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign x          = vec_q[1];
  assign y          = vec_q[0];
  assign vec_idx    = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fcnt_q;
  assign fail_map   = map_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: gate models on z, scoreboard of expected sweep results.
module tb_gate_sweep_ctrl;

  typedef struct {
    int         done_at;
    int         busy_n;
    logic [3:0] map;
    logic [2:0] fcnt;
    logic       pass;
    logic [1:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  int   mode = 0;  // 0: OR gate, 1: z stuck at 0, 2: AND gate

  logic       x, y, z, busy, done, pass;
  logic [2:0] fail_count;
  logic [3:0] fail_map;
  logic [1:0] vec_idx;
  logic       x2, y2, z2, busy2, done2, pass2;
  logic [2:0] fail_count2;
  logic [3:0] fail_map2;
  logic [1:0] vec_idx2;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [3:0] exp_tbl = 4'b1110;

  always #5 clk = ~clk;

  assign z  = (mode == 0) ? (x | y) : (mode == 1) ? 1'b0 : (x & y);
  assign z2 = x2 | y2;

  gate_sweep_ctrl #(.SETTLE_CYCLES(2), .EXPECT(4'b1110)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .z(z), .busy(busy), .done(done),
    .pass(pass), .fail_count(fail_count), .fail_map(fail_map), .vec_idx(vec_idx)
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(1), .EXPECT(4'b1110)) dut1 (
    .clk(clk), .rst(rst), .start(start2), .x(x2), .y(y2), .z(z2), .busy(busy2), .done(done2),
    .pass(pass2), .fail_count(fail_count2), .fail_map(fail_map2), .vec_idx(vec_idx2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic exp_t model(input int m, input int rst_at, input int settle);
    exp_t e;
    logic zv;
    logic [1:0] k;
    e.done_at = -1; e.busy_n = 0; e.map = 4'd0; e.fcnt = 3'd0; e.pass = 1'b0; e.vec = 2'd0;
    if (rst_at > 0) begin
      e.busy_n = rst_at;
      return e;
    end
    for (int i = 0; i < 4; i++) begin
      k = 2'(i);
      zv = (m == 0) ? (k[1] | k[0]) : (m == 1) ? 1'b0 : (k[1] & k[0]);
      e.vec = k;
      if (zv != exp_tbl[k]) begin
        e.map[k] = 1'b1;
        e.fcnt = e.fcnt + 3'd1;
`ifdef GATE_SWEEP_FAIL_STOP_EN
        break;
`endif
      end
    end
    e.pass    = (e.fcnt == 3'd0);
    e.busy_n  = (int'(e.vec) + 1) * (settle + 1);
    e.done_at = e.busy_n + 1;
    return e;
  endfunction

  // Cycle 0 is the cycle in which start is high; outputs are sampled at each negedge.
  task automatic sweep(input string name, input int m, input int restart_at, input int rst_at);
    exp_t e;
    int done_at;
    int busy_n;
    int done_n;
    mode = m;
    sb.push_back(model(m, rst_at, 2));
    done_at = -1; busy_n = 0; done_n = 0;
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      if (n > 0) begin
        if (busy) busy_n++;
        if (done) begin
          done_n++;
          if (done_at < 0) done_at = n;
        end
        check({name, ".xy_is_vec"}, {30'd0, x, y}, {30'd0, vec_idx});
      end
      if (rst_at > 0 && n == rst_at + 1) begin
        check({name, ".rst_zero"}, {19'd0, x, y, busy, done, pass, fail_count, fail_map, vec_idx}, 32'd0);
      end
      start = (n == 0) || (n == restart_at);
      rst   = (rst_at > 0) && (n == rst_at);
    end
    start = 1'b0;
    rst   = 1'b0;
    if (sb.size() == 0) begin
      check({name, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, ".done_at"}, done_at, e.done_at);
      check({name, ".done_pulses"}, done_n, (e.done_at < 0) ? 0 : 1);
      check({name, ".busy_cycles"}, busy_n, e.busy_n);
      check({name, ".fail_map"}, {28'd0, fail_map}, {28'd0, e.map});
      check({name, ".fail_count"}, {29'd0, fail_count}, {29'd0, e.fcnt});
      check({name, ".pass"}, {31'd0, pass}, {31'd0, e.pass});
      check({name, ".vec_idx"}, {30'd0, vec_idx}, {30'd0, e.vec});
    end
  endtask

  initial begin
    int done2_at;
    int busy2_n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.outputs", {19'd0, x, y, busy, done, pass, fail_count, fail_map, vec_idx}, 32'd0);
    check("reset.outputs1", {19'd0, x2, y2, busy2, done2, pass2, fail_count2, fail_map2, vec_idx2}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle.no_busy", {31'd0, busy}, 32'd0);

    sweep("or", 0, -1, -1);
    sweep("stuck0", 1, -1, -1);
    sweep("and", 2, -1, -1);
    sweep("or_after_fail", 0, -1, -1);
    sweep("restart_ignored", 2, 4, -1);
    sweep("rst_mid", 0, -1, 5);
    sweep("or_after_rst", 0, -1, -1);

    // SETTLE_CYCLES=1 instance: each vector held exactly 2 cycles, done at cycle 9
    @(negedge clk);
    start2 = 1'b1;
    done2_at = -1;
    busy2_n = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (busy2) busy2_n++;
      if (done2 && done2_at < 0) done2_at = n;
      if (n <= 8) check("s1.xy_seq", {30'd0, x2, y2}, 32'(n - 1) >> 1);
    end
    check("s1.done_at", done2_at, 9);
    check("s1.busy_cycles", busy2_n, 8);
    check("s1.pass", {31'd0, pass2}, 32'd1);
    check("s1.fail_map", {28'd0, fail_map2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
